// File: rtl/dmem_arbiter.sv
// Two-port (core A / loader B) arbiter for a single-port byte data memory with
// a registered command stage and a two-cycle read-return path with owner routing.
module dmem_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 13,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  a_req_i,
    input  logic                  a_we_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [7:0]            a_wdata_i,
    output logic                  a_gnt_o,
    output logic                  a_rvalid_o,
    output logic [7:0]            a_rdata_o,

    input  logic                  b_req_i,
    input  logic                  b_we_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic [7:0]            b_wdata_i,
    output logic                  b_gnt_o,
    output logic                  b_rvalid_o,
    output logic [7:0]            b_rdata_o,

    output logic [ADDR_WIDTH-1:0] m_w_addr_o,
    output logic [ADDR_WIDTH-1:0] m_r_addr_o,
    output logic                  m_write_en_o,
    output logic                  m_read_en_o,
    output logic [7:0]            m_din_o,
    input  logic [7:0]            m_dout_i
);

    localparam logic [3:0] StarveLim = 4'(STARVE_LIMIT);
    localparam logic [3:0] StarveMax = 4'hF;

    typedef enum logic [0:0] {StPrioA, StForceB} state_e;

    state_e     state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic       a_gnt, b_gnt;

    // ---------------------------------------------------------------- arbiter FSM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StPrioA;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        starve_d = 4'd0;
        if (b_req_i && !b_gnt) begin
            starve_d = (starve_q == StarveMax) ? StarveMax : starve_q + 4'd1;
        end
    end

    // Forcing is decided on the updated count so B wins on the very next cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StPrioA:  if (starve_d >= StarveLim) state_d = StForceB;
            StForceB: if (b_gnt || !b_req_i)     state_d = StPrioA;
            default:  state_d = StPrioA;
        endcase
    end

    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (rst_ni) begin
            unique case (state_q)
                StPrioA: begin
                    a_gnt = a_req_i;
                    b_gnt = b_req_i && !a_req_i;
                end
                StForceB: b_gnt = b_req_i;
                default: ;
            endcase
        end
    end

    assign a_gnt_o = a_gnt;
    assign b_gnt_o = b_gnt;

    // ---------------------------------------------------------------- command stage
    logic                  cmd_vld;
    logic                  cmd_we;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [7:0]            cmd_wdata;

    logic [ADDR_WIDTH-1:0] m_addr_q;
    logic [7:0]            m_din_q;
    logic                  m_wr_q, m_rd_q;
    logic                  rd_owner_b_q;

    always_comb begin
        cmd_vld   = a_gnt || b_gnt;
        cmd_we    = b_gnt ? b_we_i    : a_we_i;
        cmd_addr  = b_gnt ? b_addr_i  : a_addr_i;
        cmd_wdata = b_gnt ? b_wdata_i : a_wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_addr_q     <= '0;
            m_din_q      <= 8'd0;
            m_wr_q       <= 1'b0;
            m_rd_q       <= 1'b0;
            rd_owner_b_q <= 1'b0;
        end else begin
            m_wr_q       <= cmd_vld && cmd_we;
            m_rd_q       <= cmd_vld && !cmd_we;
            rd_owner_b_q <= b_gnt;
            if (cmd_vld) begin
                m_addr_q <= cmd_addr;
                m_din_q  <= cmd_wdata;
            end
        end
    end

    assign m_w_addr_o   = m_addr_q;
    assign m_r_addr_o   = m_addr_q;
    assign m_write_en_o = m_wr_q;
    assign m_read_en_o  = m_rd_q;
    assign m_din_o      = m_din_q;

    // ---------------------------------------------------------------- read return
    logic       a_rvalid_q, b_rvalid_q;
    logic [7:0] a_rdata_q, b_rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= 8'd0;
            b_rdata_q  <= 8'd0;
        end else begin
            a_rvalid_q <= m_rd_q && !rd_owner_b_q;
            b_rvalid_q <= m_rd_q && rd_owner_b_q;
            if (m_rd_q && !rd_owner_b_q) a_rdata_q <= m_dout_i;
            if (m_rd_q && rd_owner_b_q)  b_rdata_q <= m_dout_i;
        end
    end

    assign a_rvalid_o = a_rvalid_q;
    assign b_rvalid_o = b_rvalid_q;
    assign a_rdata_o  = a_rdata_q;
    assign b_rdata_o  = b_rdata_q;

    // ---------------------------------------------------------------- properties
    a_gnt_needs_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
        a_gnt |-> a_req_i);
    b_gnt_needs_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
        b_gnt |-> b_req_i);
    gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(a_gnt && b_gnt));
    rvalid_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(a_rvalid_q && b_rvalid_q));

endmodule
